// File: rtl/resp_collect_pkg.sv
// Shared FSM state encoding and default MISR constants for the response collector.
package resp_collect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'h0000_0000;

endpackage

// File: rtl/resp_misr_collector_misr_step.sv
// misr_step: one MISR compaction step (shift left, conditional POLY feedback, XOR in data).
// Purely combinational; usable by a reference model as well as the collector.
module misr_step #(
  parameter int               W    = 32,
  parameter logic [W-1:0]     POLY = '0
) (
  input  logic [W-1:0] sig,
  input  logic [W-1:0] data,
  output logic [W-1:0] next
);

  assign next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ data;

endmodule

// File: rtl/resp_misr_collector.sv
// Response MISR collector: compacts VEC_LENGTH beats, then checks against golden_sig (RESP_VEC_COMPARE_EN adds per-beat compare).
// Latency: one beat per cycle in RUN; done/pass valid two cycles after the last accepted beat.
// Backpressure: resp_ready only in RUN; beats offered outside RUN are dropped, never buffered.
module resp_misr_collector
  import resp_collect_pkg::*;
#(
  parameter int                   OUT_WIDTH  = 32,
  parameter int                   VEC_LENGTH = 7,
  parameter logic [OUT_WIDTH-1:0] POLY       = DEF_POLY[OUT_WIDTH-1:0],
  parameter logic [OUT_WIDTH-1:0] SEED       = DEF_SEED[OUT_WIDTH-1:0],
  localparam int                  CW         = $clog2(VEC_LENGTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 resp_valid,
  input  logic [OUT_WIDTH-1:0] resp_data,
  output logic                 resp_ready,
  input  logic [OUT_WIDTH-1:0] golden_sig,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [OUT_WIDTH-1:0] signature,
  output logic [CW-1:0]        vec_count
`ifdef RESP_VEC_COMPARE_EN
  ,
  input  logic [OUT_WIDTH-1:0] exp_data,
  output logic [CW-1:0]        mismatch_cnt,
  output logic [CW-1:0]        first_fail_idx
`endif
);

  state_t               state;
  logic [OUT_WIDTH-1:0] sig_next;
  logic                 accept;

  misr_step #(
    .W    (OUT_WIDTH),
    .POLY (POLY)
  ) u_step (
    .sig  (signature),
    .data (resp_data),
    .next (sig_next)
  );

  // Handshake outputs decode from state only, so there is no input-to-output path.
  assign resp_ready = (state == ST_RUN);
  assign busy       = (state == ST_RUN) || (state == ST_CHECK);
  assign done       = (state == ST_DONE);
  assign accept     = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      signature      <= SEED;
      vec_count      <= '0;
      pass           <= 1'b0;
`ifdef RESP_VEC_COMPARE_EN
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_RUN;
            signature      <= SEED;
            vec_count      <= '0;
            pass           <= 1'b0;
`ifdef RESP_VEC_COMPARE_EN
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (accept) begin
            signature <= sig_next;
            vec_count <= vec_count + CW'(1);
            if (vec_count == CW'(VEC_LENGTH - 1)) begin
              state <= ST_CHECK;
            end
`ifdef RESP_VEC_COMPARE_EN
            if (resp_data != exp_data) begin
              mismatch_cnt <= mismatch_cnt + CW'(1);
              if (mismatch_cnt == '0) begin
                first_fail_idx <= vec_count;
              end
            end
`endif
          end
        end
        ST_CHECK: begin
`ifdef RESP_VEC_COMPARE_EN
          pass <= (signature == golden_sig) && (mismatch_cnt == '0);
`else
          pass <= (signature == golden_sig);
`endif
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resp_misr_collector.sv
// Directed bench for resp_misr_collector (8-bit, POLY 8'h1D, 3 beats); covers RESP_VEC_COMPARE_EN when defined.
module tb_resp_misr_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_ready;
  logic [7:0] golden_sig;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;
  logic [1:0] vec_count;
`ifdef RESP_VEC_COMPARE_EN
  logic [7:0] exp_data;
  logic [1:0] mismatch_cnt;
  logic [1:0] first_fail_idx;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  resp_misr_collector #(
    .OUT_WIDTH  (8),
    .VEC_LENGTH (3),
    .POLY       (8'h1D),
    .SEED       (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_ready     (resp_ready),
    .golden_sig     (golden_sig),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .signature      (signature),
    .vec_count      (vec_count)
`ifdef RESP_VEC_COMPARE_EN
    ,
    .exp_data       (exp_data),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_idx (first_fail_idx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one beat for one cycle; exp is the per-beat reference used in compare builds.
  task automatic beat(input logic [7:0] d, input logic [7:0] e);
    resp_valid = 1'b1;
    resp_data  = d;
`ifdef RESP_VEC_COMPARE_EN
    exp_data   = e;
`else
    if (e != d) resp_data = d;
`endif
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, resp_ready, 0);
    chk({tag, "_busy"},  busy,       0);
    chk({tag, "_done"},  done,       0);
    chk({tag, "_pass"},  pass,       0);
    chk({tag, "_sig"},   signature,  0);
    chk({tag, "_cnt"},   vec_count,  0);
  endtask

  // Full session with beats 01, 80, 00: signatures 01, 82, 19.
  task automatic session(input string tag, input logic [7:0] gold, input logic exp_pass);
    golden_sig = gold;
    pulse_start();
    chk({tag, "_ready_run"}, resp_ready, 1);
    chk({tag, "_busy_run"},  busy,       1);
    beat(8'h01, 8'h01);
    chk({tag, "_sig1"}, signature, 8'h01);
    beat(8'h80, 8'h80);
    chk({tag, "_sig2"}, signature, 8'h82);
    chk({tag, "_cnt2"}, vec_count, 2);
    beat(8'h00, 8'h00);
    chk({tag, "_sig3"},        signature,  8'h19);
    chk({tag, "_ready_check"}, resp_ready, 0);
    chk({tag, "_done_check"},  done,       0);
    tick();
    chk({tag, "_done"}, done,      1);
    chk({tag, "_pass"}, pass,      exp_pass);
    chk({tag, "_sigf"}, signature, 8'h19);
    chk({tag, "_cntf"}, vec_count, 3);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 8'h00;
    golden_sig = 8'h19;
`ifdef RESP_VEC_COMPARE_EN
    exp_data   = 8'h00;
`endif
    tick();
    tick();
    rst = 1'b0;
    check_reset("rst");

    // Beats offered in IDLE are dropped.
    beat(8'hFF, 8'hFF);
    chk("idle_drop_sig", signature, 8'h00);
    chk("idle_drop_cnt", vec_count, 0);

    session("good", 8'h19, 1'b1);
    session("bad",  8'h18, 1'b0);

    // Valid held high in DONE must not disturb the held result.
    resp_valid = 1'b1;
    resp_data  = 8'hA5;
    tick();
    tick();
    resp_valid = 1'b0;
    chk("done_hold_sig",  signature, 8'h19);
    chk("done_hold_cnt",  vec_count, 3);
    chk("done_hold_pass", pass,      0);

    // Gaps between beats, then valid left high through CHECK/DONE.
    golden_sig = 8'h19;
    pulse_start();
    chk("gap_clear_pass", pass, 0);
    chk("gap_clear_cnt",  vec_count, 0);
    tick();
    beat(8'h01, 8'h01);
    tick();
    tick();
    chk("gap_cnt1", vec_count, 1);
    beat(8'h80, 8'h80);
    resp_valid = 1'b1;
    resp_data  = 8'h00;
`ifdef RESP_VEC_COMPARE_EN
    exp_data   = 8'h00;
`endif
    tick();
    resp_data = 8'h5A;
    tick();
    tick();
    tick();
    resp_valid = 1'b0;
    chk("gap_sig",  signature, 8'h19);
    chk("gap_cnt",  vec_count, 3);
    chk("gap_done", done,      1);
    chk("gap_pass", pass,      1);

    // Reset mid-session discards partial state.
    pulse_start();
    beat(8'h01, 8'h01);
    beat(8'h80, 8'h80);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("midrst");
    session("after_rst", 8'h19, 1'b1);

    // Start during RUN is ignored.
    pulse_start();
    beat(8'h01, 8'h01);
    start = 1'b1;
    beat(8'h80, 8'h80);
    start = 1'b0;
    chk("restart_cnt", vec_count, 2);
    chk("restart_sig", signature, 8'h82);
    beat(8'h00, 8'h00);
    tick();
    chk("restart_pass", pass, 1);

`ifdef RESP_VEC_COMPARE_EN
    chk("cmp_clean_mm", mismatch_cnt, 0);
    golden_sig = 8'h19;
    pulse_start();
    beat(8'h01, 8'h01);
    beat(8'h80, 8'h81);
    beat(8'h00, 8'h00);
    tick();
    chk("cmp_mm",   mismatch_cnt,   1);
    chk("cmp_ffi",  first_fail_idx, 1);
    chk("cmp_sig",  signature,      8'h19);
    chk("cmp_pass", pass,           0);
    pulse_start();
    chk("cmp_clr_mm",  mismatch_cnt,   0);
    chk("cmp_clr_ffi", first_fail_idx, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
